// File: rtl/osd_stm_trace_pkg.sv
// Shared constants and types for the STM trace-port feeder.
package osd_stm_trace_pkg;

    // Register map of the memory-mapped trace port
    localparam logic [1:0] STM_TP_VALUE = 2'd0;
    localparam logic [1:0] STM_TP_ID    = 2'd1;
    localparam logic [1:0] STM_TP_CTRL  = 2'd2;

    // Bit positions inside a CTRL write
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CLR    = 1;

    // Value-assembly state machine
    typedef enum logic {
        IDLE,
        COLLECT
    } stm_tp_state_e;

endpackage

// File: rtl/osd_stm_trace_port.sv
// Trace-port feeder: collects CPU value words, then turns an ID write into a
// single-cycle trace event for the system trace module.
module osd_stm_trace_port #(
    parameter int XLEN     = 32,
    parameter int VALWIDTH = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [1:0]          wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    output logic                trace_valid_o,
    output logic [15:0]         trace_id_o,
    output logic [VALWIDTH-1:0] trace_value_o,
    output logic                err_o,
    output logic [15:0]         event_count_o,
    output logic [15:0]         drop_count_o
);

    import osd_stm_trace_pkg::*;

    localparam int NWORDS = VALWIDTH / XLEN;
    localparam int IDXW   = $clog2(NWORDS + 1);
    localparam logic [IDXW-1:0] NWORDS_L = IDXW'(NWORDS);

    stm_tp_state_e        state_q, state_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [VALWIDTH-1:0]  staging_q, staging_d;
    logic                 enable_q, enable_d;
    logic                 err_q, err_d;
    logic [15:0]          event_count_q, event_count_d;
    logic [15:0]          drop_count_q, drop_count_d;
    logic                 trace_valid_q, trace_valid_d;
    logic [15:0]          trace_id_q, trace_id_d;
    logic [VALWIDTH-1:0]  trace_value_q, trace_value_d;
    logic                 ready_q, ready_d;

    // Register all state; ready comes up one edge after reset release so the
    // deassertion is seen synchronously by the write path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            staging_q     <= '0;
            enable_q      <= 1'b1;
            err_q         <= 1'b0;
            event_count_q <= '0;
            drop_count_q  <= '0;
            trace_valid_q <= 1'b0;
            trace_id_q    <= '0;
            trace_value_q <= '0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            staging_q     <= staging_d;
            enable_q      <= enable_d;
            err_q         <= err_d;
            event_count_q <= event_count_d;
            drop_count_q  <= drop_count_d;
            trace_valid_q <= trace_valid_d;
            trace_id_q    <= trace_id_d;
            trace_value_q <= trace_value_d;
            ready_q       <= ready_d;
        end
    end

    // Decode an accepted write into next-state for staging, FSM, counters and event.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        staging_d     = staging_q;
        enable_d      = enable_q;
        err_d         = err_q;
        event_count_d = event_count_q;
        drop_count_d  = drop_count_q;
        trace_valid_d = 1'b0;
        trace_id_d    = trace_id_q;
        trace_value_d = trace_value_q;
        ready_d       = 1'b1;

        if (wr_valid_i && ready_q) begin
            case (wr_addr_i)
                STM_TP_VALUE: begin
                    if (state_q == IDLE) begin
                        staging_d[XLEN-1:0] = wr_data_i;
                        if (NWORDS == 1) begin
                            idx_d   = '0;
                            state_d = IDLE;
                        end else begin
                            idx_d   = IDXW'(1);
                            state_d = COLLECT;
                        end
                    end else if (idx_q < NWORDS_L) begin
                        staging_d[int'(idx_q)*XLEN +: XLEN] = wr_data_i;
                        idx_d = idx_q + IDXW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                STM_TP_ID: begin
                    if (enable_q) begin
                        trace_valid_d = 1'b1;
                        trace_id_d    = wr_data_i[15:0];
                        trace_value_d = staging_q;
                        event_count_d = event_count_q + 16'd1;
                    end else if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end
                    staging_d = '0;
                    idx_d     = '0;
                    state_d   = IDLE;
                end
                STM_TP_CTRL: begin
                    enable_d = wr_data_i[CTRL_ENABLE];
                    if (wr_data_i[CTRL_CLR]) begin
                        err_d        = 1'b0;
                        drop_count_d = '0;
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    assign wr_ready_o    = ready_q;
    assign trace_valid_o = trace_valid_q;
    assign trace_id_o    = trace_id_q;
    assign trace_value_o = trace_value_q;
    assign err_o         = err_q;
    assign event_count_o = event_count_q;
    assign drop_count_o  = drop_count_q;

endmodule

// File: tb/tb_osd_stm_trace_port.sv
// Self-checking bench for the STM trace-port feeder with a queue-based model.
module tb_osd_stm_trace_port;

    localparam int XLEN     = 32;
    localparam int VALWIDTH = 64;
    localparam int NWORDS   = VALWIDTH / XLEN;

    logic                clk_i;
    logic                rst_ni;
    logic                wr_valid_i;
    logic                wr_ready_o;
    logic [1:0]          wr_addr_i;
    logic [XLEN-1:0]     wr_data_i;
    logic                trace_valid_o;
    logic [15:0]         trace_id_o;
    logic [VALWIDTH-1:0] trace_value_o;
    logic                err_o;
    logic [15:0]         event_count_o;
    logic [15:0]         drop_count_o;

    int checks = 0;
    int errors = 0;

    // Reference model: pending words in write order, plus flags and counters
    logic [XLEN-1:0]     m_words[$];
    logic                m_enable;
    logic                m_err;
    int                  m_events;
    int                  m_drops;
    logic                m_valid;
    logic [15:0]         m_id;
    logic [VALWIDTH-1:0] m_value;

    osd_stm_trace_port #(.XLEN(XLEN), .VALWIDTH(VALWIDTH)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .trace_valid_o (trace_valid_o),
        .trace_id_o    (trace_id_o),
        .trace_value_o (trace_value_o),
        .err_o         (err_o),
        .event_count_o (event_count_o),
        .drop_count_o  (drop_count_o)
    );

    // Free-running clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Put the model into its post-reset state
    task automatic modelReset();
        m_words.delete();
        m_enable = 1'b1;
        m_err    = 1'b0;
        m_events = 0;
        m_drops  = 0;
        m_valid  = 1'b0;
        m_id     = '0;
        m_value  = '0;
    endtask

    // Drive one cycle (from a negedge), let the model absorb the write, end at the next negedge
    task automatic applyStimulus(input logic v, input logic [1:0] a, input logic [XLEN-1:0] d);
        wr_valid_i = v;
        wr_addr_i  = a;
        wr_data_i  = d;
        @(posedge clk_i);
        m_valid = 1'b0;
        if (v) begin
            case (a)
                2'd0: begin
                    if (m_words.size() < NWORDS) m_words.push_back(d);
                    else m_err = 1'b1;
                end
                2'd1: begin
                    if (m_enable) begin
                        m_valid = 1'b1;
                        m_id    = d[15:0];
                        m_value = '0;
                        for (int i = 0; i < m_words.size(); i++)
                            m_value = m_value | (VALWIDTH'(m_words[i]) << (XLEN * i));
                        m_events = (m_events + 1) % 65536;
                    end else if (m_drops < 65535) begin
                        m_drops = m_drops + 1;
                    end
                    m_words.delete();
                end
                2'd2: begin
                    m_enable = d[0];
                    if (d[1]) begin
                        m_err   = 1'b0;
                        m_drops = 0;
                    end
                end
                default: m_err = 1'b1;
            endcase
        end
        @(negedge clk_i);
        wr_valid_i = 1'b0;
    endtask

    // Asynchronous reset pulse between edges, then wait until writes are accepted again
    task automatic pulseReset();
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        modelReset();
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        checks++;
        if (wr_ready_o !== 1'b0 || trace_valid_o !== 1'b0 || trace_id_o !== 16'h0 ||
            trace_value_o !== '0 || err_o !== 1'b0 || event_count_o !== 16'h0 || drop_count_o !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b valid=%b id=%h value=%h err=%b ev=%h drop=%h, required all zero",
                     wr_ready_o, trace_valid_o, trace_id_o, trace_value_o, err_o, event_count_o, drop_count_o);
        end
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        modelReset();
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (wr_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: got %b, required 1", wr_ready_o);
        end
    endtask

    task automatic test_basic();
        applyStimulus(1'b1, 2'd0, 32'hDEADBEEF);
        applyStimulus(1'b1, 2'd0, 32'h01234567);
        applyStimulus(1'b1, 2'd1, 32'h000000A5);
        checks++;
        if (trace_valid_o !== 1'b1 || trace_id_o !== 16'h00A5 ||
            trace_value_o !== 64'h01234567_DEADBEEF || event_count_o !== 16'd1) begin
            errors++;
            $display("[TB] FAIL basic_event: valid=%b id=%h value=%h ev=%0d, required 1 00a5 01234567deadbeef 1",
                     trace_valid_o, trace_id_o, trace_value_o, event_count_o);
        end
        applyStimulus(1'b0, 2'd0, 32'h0);
        checks++;
        if (trace_valid_o !== 1'b0 || trace_id_o !== 16'h00A5 || trace_value_o !== 64'h01234567_DEADBEEF) begin
            errors++;
            $display("[TB] FAIL basic_hold: valid=%b id=%h value=%h, required 0 00a5 01234567deadbeef",
                     trace_valid_o, trace_id_o, trace_value_o);
        end
    endtask

    task automatic test_partial_and_overrun();
        applyStimulus(1'b1, 2'd0, 32'h00000011);
        applyStimulus(1'b1, 2'd1, 32'h00000002);
        checks++;
        if (trace_valid_o !== 1'b1 || trace_id_o !== 16'h0002 || trace_value_o !== 64'h00000000_00000011) begin
            errors++;
            $display("[TB] FAIL partial_value: valid=%b id=%h value=%h, required 1 0002 0000000000000011",
                     trace_valid_o, trace_id_o, trace_value_o);
        end
        applyStimulus(1'b1, 2'd0, 32'h0000000A);
        applyStimulus(1'b1, 2'd0, 32'h0000000B);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_early_err: got %b, required 0", err_o);
        end
        applyStimulus(1'b1, 2'd0, 32'h0000000C);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_err: got %b, required 1", err_o);
        end
        applyStimulus(1'b1, 2'd1, 32'h00000004);
        checks++;
        if (trace_valid_o !== 1'b1 || trace_value_o !== 64'h0000000B_0000000A || trace_value_o !== m_value) begin
            errors++;
            $display("[TB] FAIL overrun_value: valid=%b value=%h, required 1 0000000b0000000a", trace_valid_o, trace_value_o);
        end
    endtask

    task automatic test_disable();
        logic [15:0] ev_before;
        ev_before = 16'(m_events);
        applyStimulus(1'b1, 2'd2, 32'h0);
        applyStimulus(1'b1, 2'd0, 32'h5);
        applyStimulus(1'b1, 2'd1, 32'h7);
        checks++;
        if (trace_valid_o !== 1'b0 || drop_count_o !== 16'd1 || event_count_o !== ev_before) begin
            errors++;
            $display("[TB] FAIL disabled_drop: valid=%b drop=%0d ev=%0d, required 0 1 %0d",
                     trace_valid_o, drop_count_o, event_count_o, ev_before);
        end
        applyStimulus(1'b1, 2'd2, 32'h1);
        applyStimulus(1'b1, 2'd1, 32'h8);
        checks++;
        if (trace_valid_o !== 1'b1 || trace_id_o !== 16'h0008 || trace_value_o !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reenable_event: valid=%b id=%h value=%h, required 1 0008 0",
                     trace_valid_o, trace_id_o, trace_value_o);
        end
    endtask

    task automatic test_back_to_back();
        pulseReset();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 2'd1, XLEN'(i));
            checks++;
            if (trace_valid_o !== 1'b1 || trace_id_o !== 16'(i) || trace_value_o !== 64'h0) begin
                errors++;
                $display("[TB] FAIL b2b_event%0d: valid=%b id=%h value=%h, required 1 %h 0",
                         i, trace_valid_o, trace_id_o, trace_value_o, 16'(i));
            end
        end
        checks++;
        if (event_count_o !== 16'd3) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d, required 3", event_count_o);
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 2'd0, 32'h0000AAAA);
        pulseReset();
        checks++;
        if (trace_valid_o !== 1'b0 || event_count_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_state: valid=%b ev=%0d, required 0 0", trace_valid_o, event_count_o);
        end
        applyStimulus(1'b1, 2'd1, 32'h9);
        checks++;
        if (trace_valid_o !== 1'b1 || trace_id_o !== 16'h0009 || trace_value_o !== 64'h0 || event_count_o !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midreset_event: valid=%b id=%h value=%h ev=%0d, required 1 0009 0 1",
                     trace_valid_o, trace_id_o, trace_value_o, event_count_o);
        end
    endtask

    task automatic test_reserved();
        applyStimulus(1'b1, 2'd2, 32'h0);
        applyStimulus(1'b1, 2'd1, 32'h1);
        applyStimulus(1'b1, 2'd3, 32'hFFFF);
        checks++;
        if (err_o !== 1'b1 || drop_count_o !== 16'd1) begin
            errors++;
            $display("[TB] FAIL reserved_err: err=%b drop=%0d, required 1 1", err_o, drop_count_o);
        end
        applyStimulus(1'b1, 2'd2, 32'h3);
        checks++;
        if (err_o !== 1'b0 || drop_count_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL ctrl_clear: err=%b drop=%0d, required 0 0", err_o, drop_count_o);
        end
        applyStimulus(1'b1, 2'd1, 32'h00001234);
        checks++;
        if (trace_valid_o !== 1'b1 || trace_id_o !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL ctrl_enable: valid=%b id=%h, required 1 1234", trace_valid_o, trace_id_o);
        end
    endtask

    task automatic test_random();
        int r;
        logic       v;
        logic [1:0] a;
        logic [31:0] d;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            a = (r < 40) ? 2'd0 : (r < 75) ? 2'd1 : (r < 92) ? 2'd2 : 2'd3;
            d = $urandom;
            if (a == 2'd2) begin
                d[0] = ($urandom_range(0, 3) != 0);
                d[1] = ($urandom_range(0, 4) == 0);
            end
            applyStimulus(v, a, d);
            checks++;
            if (trace_valid_o !== m_valid || trace_id_o !== m_id || trace_value_o !== m_value) begin
                errors++;
                $display("[TB] FAIL rand_event step %0d: valid=%b id=%h value=%h, required %b %h %h",
                         n, trace_valid_o, trace_id_o, trace_value_o, m_valid, m_id, m_value);
            end
            checks++;
            if (err_o !== m_err || event_count_o !== 16'(m_events) || drop_count_o !== 16'(m_drops)) begin
                errors++;
                $display("[TB] FAIL rand_status step %0d: err=%b ev=%0d drop=%0d, required %b %0d %0d",
                         n, err_o, event_count_o, drop_count_o, m_err, m_events, m_drops);
            end
        end
    endtask

    // Run every scenario in order and report
    initial begin
        rst_ni     = 1'b1;
        wr_valid_i = 1'b0;
        wr_addr_i  = 2'd0;
        wr_data_i  = '0;
        modelReset();
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_partial_and_overrun();
        test_disable();
        test_back_to_back();
        test_reset_mid();
        test_reserved();
        pulseReset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/osd_stm_trace_port.md
Name: osd_stm_trace_port

Overview:
- Upstream feeder for the system trace module.
- Converts a CPU's memory-mapped trace-port writes (value words, then an ID write) into single-cycle trace events: trace_valid, trace_id, trace_value.
- Sits between the core's store path (or uncached peripheral decode) and the STM trace inputs.
- Assembles values wider than the CPU word, gates events with an enable bit, and keeps event and drop counters.

Parameters:
- XLEN, 32, CPU write-data width; must divide VALWIDTH.
- VALWIDTH, 64, trace value width; must match the downstream STM.
- NWORDS, VALWIDTH/XLEN (localparam), value words per event.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- wr_valid  in  1  CPU write request.
- wr_ready  out  1  write accepted; constant 1 outside reset.
- wr_addr  in  2  register select: 0 = VALUE, 1 = ID (trigger), 2 = CTRL, 3 = reserved.
- wr_data  in  XLEN  write data.
- trace_valid  out  1  one-cycle event strobe.
- trace_id  out  16  event ID.
- trace_value  out  VALWIDTH  event value.
- err  out  1  sticky: VALUE overrun or reserved-address write.
- event_count  out  16  events emitted, wraps.
- drop_count  out  16  triggers dropped while disabled, saturates at FFFF.

Behaviour:
- Reset (rst=0, async assert, sync deassert):
  - trace_valid=0, trace_id=0, trace_value=0, err=0, event_count=0, drop_count=0.
  - staging=0, idx=0, enable=1, FSM=IDLE.
- A write is accepted when wr_valid & wr_ready. wr_ready=0 during reset, 1 otherwise.
- FSM states:
  - IDLE: idx=0. VALUE write -> staging word 0 = wr_data, idx=1, go to COLLECT (or stay in IDLE with idx reset to 0 if NWORDS=1, value already complete).
  - COLLECT: VALUE write with idx<NWORDS -> staging word idx = wr_data, idx++.
  - COLLECT: VALUE write with idx==NWORDS -> data discarded, err set, idx unchanged.
  - ID write in any state -> trigger.
- Word order is LSW first. Unwritten words are 0 at trigger time.
- Trigger (ID write):
  - If enable=1: next cycle trace_valid=1, trace_id=wr_data[15:0], trace_value=staging; event_count++ (wraps FFFF->0).
  - If enable=0: no strobe; drop_count++ (saturating).
  - Either way: staging cleared to 0, idx=0, FSM -> IDLE on the same edge.
- Latency: ID write accepted at edge N -> trace_valid high for the cycle after edge N, low after edge N+1 unless another trigger arrives.
- Back-to-back ID writes give back-to-back strobes; the second carries a zero value unless VALUE writes intervene (impossible on a single port).
- trace_id and trace_value hold their last values while trace_valid=0.
- CTRL write:
  - enable = wr_data[0].
  - wr_data[1]=1 clears err and drop_count.
  - Staging and FSM are unaffected.
- Reserved-address write sets err; no other effect.
- No backpressure exists from downstream (the STM drops on stall), so wr_ready never deasserts for trace reasons.
- Reset mid-collection discards partial staging; no event is emitted.

Decomposition:
- Package osd_stm_trace_pkg holds:
  - address constants STM_TP_VALUE=2'd0, STM_TP_ID=2'd1, STM_TP_CTRL=2'd2;
  - CTRL bit indices CTRL_ENABLE=0, CTRL_CLR=1;
  - enum typedef for FSM states {IDLE, COLLECT}.
- Single module; no sub-module is warranted. Counters and staging are inline.

Test Plan:
- Reset release, then VALUE 0xDEADBEEF, VALUE 0x01234567, ID 0x00A5 -> one cycle later trace_valid=1, trace_id=0x00A5, trace_value=0x01234567_DEADBEEF, event_count=1; next cycle trace_valid=0.
- VALUE 0x11, ID 0x0002 -> trace_value=0x00000000_00000011; a third VALUE write before the ID in a separate run -> err=1, value still the first two words.
- CTRL 0x0, VALUE 0x5, ID 0x7 -> no trace_valid, drop_count=1, event_count unchanged; CTRL 0x1, then ID 0x8 -> strobe with trace_value=0 (staging cleared by the dropped trigger).
- ID 0x1, ID 0x2, ID 0x3 on consecutive cycles -> trace_valid high for 3 consecutive cycles with IDs 1, 2, 3; event_count=3.
- VALUE 0xAAAA, assert rst=0 for 1 cycle asynchronously, release, ID 0x9 -> trace_value=0, all counters restart (event_count=1).
- Write to address 3 -> err=1; CTRL 0x3 -> err=0, drop_count=0, enable=1.
